// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and defaults for the execute-stage ALU with
// iterative multiply/divide.
package alu_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned OP_W         = 5;

  localparam logic [OP_W-1:0] OP_ADD    = 5'd0;
  localparam logic [OP_W-1:0] OP_SUB    = 5'd1;
  localparam logic [OP_W-1:0] OP_AND    = 5'd2;
  localparam logic [OP_W-1:0] OP_OR     = 5'd3;
  localparam logic [OP_W-1:0] OP_XOR    = 5'd4;
  localparam logic [OP_W-1:0] OP_SLL    = 5'd5;
  localparam logic [OP_W-1:0] OP_SRL    = 5'd6;
  localparam logic [OP_W-1:0] OP_SRA    = 5'd7;
  localparam logic [OP_W-1:0] OP_SLT    = 5'd8;
  localparam logic [OP_W-1:0] OP_SLTU   = 5'd9;
  localparam logic [OP_W-1:0] OP_MUL    = 5'd16;
  localparam logic [OP_W-1:0] OP_MULH   = 5'd17;
  localparam logic [OP_W-1:0] OP_MULHSU = 5'd18;
  localparam logic [OP_W-1:0] OP_MULHU  = 5'd19;
  localparam logic [OP_W-1:0] OP_DIV    = 5'd20;
  localparam logic [OP_W-1:0] OP_DIVU   = 5'd21;
  localparam logic [OP_W-1:0] OP_REM    = 5'd22;
  localparam logic [OP_W-1:0] OP_REMU   = 5'd23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // MUL family occupies 16..19, DIV/REM family 20..23.
  function automatic logic is_mul(input logic [OP_W-1:0] op);
    return op[4:2] == 3'b100;
  endfunction

  function automatic logic is_div(input logic [OP_W-1:0] op);
    return op[4:2] == 3'b101;
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// Shared radix-2 datapath: right-shifting shift-add multiply and restoring
// divide on unsigned magnitudes, one step per cycle while i_step is high.
module md_iter_core
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_is_div,
  input  logic            i_step,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_done_c,
  output logic [XLEN-1:0] o_hi_c,
  output logic [XLEN-1:0] o_lo_c
);

  localparam int unsigned CW = $clog2(XLEN);

  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] sr_q, sr_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            div_q, div_d;

  logic [XLEN:0]   sum_c, shl_c, diff_c;
  logic [XLEN-1:0] acc_step_c, sr_step_c;

  // One iteration: product {acc,sr} shifts right; remainder:quotient shifts left.
  always_comb begin
    sum_c  = {1'b0, acc_q} + {1'b0, (sr_q[0] ? opnd_q : {XLEN{1'b0}})};
    shl_c  = {acc_q, sr_q[XLEN-1]};
    diff_c = shl_c - {1'b0, opnd_q};
    if (div_q) begin
      if (!diff_c[XLEN]) begin
        acc_step_c = diff_c[XLEN-1:0];
        sr_step_c  = {sr_q[XLEN-2:0], 1'b1};
      end else begin
        acc_step_c = shl_c[XLEN-1:0];
        sr_step_c  = {sr_q[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_step_c = sum_c[XLEN:1];
      sr_step_c  = {sum_c[0], sr_q[XLEN-1:1]};
    end
  end

  assign o_hi_c   = acc_step_c;
  assign o_lo_c   = sr_step_c;
  assign o_done_c = (cnt_q == '0);

  always_comb begin
    acc_d  = acc_q;
    sr_d   = sr_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    if (i_start) begin
      acc_d  = '0;
      sr_d   = i_is_div ? i_a : i_b;
      opnd_d = i_is_div ? i_b : i_a;
      cnt_d  = CW'(XLEN - 1);
      div_d  = i_is_div;
    end else if (i_step) begin
      acc_d = acc_step_c;
      sr_d  = sr_step_c;
      if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q  <= '0;
      sr_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      sr_q   <= sr_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
    end
  end

endmodule

// File: rtl/alu_md_unit.sv
// Execute-stage ALU with RV32M multiply/divide behind a valid/ready handshake.
// Build option ALU_MD_FAST_MUL_EN: single-cycle combinational MUL* instead of iterative.
module alu_md_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [4:0]      i_op,
  input  logic [XLEN-1:0] i_A,
  input  logic [XLEN-1:0] i_B,
  input  logic            i_kill,
  output logic            o_valid,
  output logic [XLEN-1:0] o_Y
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned PW  = 2 * XLEN;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_q, state_d;
  logic            ready_q, ready_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] y_q, y_d;
  logic [4:0]      op_q, op_d;
  logic            a_neg_q, a_neg_d;
  logic            b_neg_q, b_neg_d;

  logic            accept_c, mul_op_c, div_op_c, iter_op_c;
  logic            a_sgn_c, b_sgn_c, a_neg_c, b_neg_c;
  logic            div_zero_c, div_ovf_c;
  logic [XLEN-1:0] a_mag_c, b_mag_c;
  logic [SHW-1:0]  shamt_c;
  logic [XLEN-1:0] base_y_c, imm_y_c, iter_y_c;
  logic [PW-1:0]   full_c, prod_c;
  logic [XLEN-1:0] quo_c, rem_c;
  logic            core_done_c;
  logic [XLEN-1:0] core_hi_c, core_lo_c;

  assign accept_c = i_valid & ready_q & ~i_kill;
  assign mul_op_c = is_mul(i_op);
  assign div_op_c = is_div(i_op);

  // Operand signedness and magnitudes for the unsigned iterative engine.
  assign a_sgn_c = (i_op == OP_MULH) | (i_op == OP_MULHSU) | (i_op == OP_DIV) | (i_op == OP_REM);
  assign b_sgn_c = (i_op == OP_MULH) | (i_op == OP_DIV) | (i_op == OP_REM);
  assign a_neg_c = a_sgn_c & i_A[XLEN-1];
  assign b_neg_c = b_sgn_c & i_B[XLEN-1];
  assign a_mag_c = a_neg_c ? (XLEN'(0) - i_A) : i_A;
  assign b_mag_c = b_neg_c ? (XLEN'(0) - i_B) : i_B;

  assign div_zero_c = div_op_c & (i_B == '0);
  assign div_ovf_c  = ((i_op == OP_DIV) | (i_op == OP_REM)) & (i_A == INT_MIN) & (i_B == '1);

`ifdef ALU_MD_FAST_MUL_EN
  logic [PW-1:0] fa_c, fb_c, fp_c;
  assign fa_c = {{XLEN{a_neg_c}}, i_A};
  assign fb_c = {{XLEN{b_neg_c}}, i_B};
  assign fp_c = fa_c * fb_c;
  assign iter_op_c = div_op_c & ~div_zero_c & ~div_ovf_c;
`else
  assign iter_op_c = mul_op_c | (div_op_c & ~div_zero_c & ~div_ovf_c);
`endif

  assign shamt_c = i_B[SHW-1:0];

  always_comb begin
    case (i_op)
      OP_SUB:  base_y_c = i_A - i_B;
      OP_AND:  base_y_c = i_A & i_B;
      OP_OR:   base_y_c = i_A | i_B;
      OP_XOR:  base_y_c = i_A ^ i_B;
      OP_SLL:  base_y_c = i_A << shamt_c;
      OP_SRL:  base_y_c = i_A >> shamt_c;
      OP_SRA:  base_y_c = XLEN'($signed(i_A) >>> shamt_c);
      OP_SLT:  base_y_c = {{(XLEN-1){1'b0}}, $signed(i_A) < $signed(i_B)};
      OP_SLTU: base_y_c = {{(XLEN-1){1'b0}}, i_A < i_B};
      default: base_y_c = i_A + i_B;
    endcase
  end

  // Results available in the accept cycle: base ops, divide special cases, fast MUL.
  always_comb begin
    imm_y_c = base_y_c;
    if (div_zero_c) begin
      imm_y_c = ((i_op == OP_DIV) | (i_op == OP_DIVU)) ? '1 : i_A;
    end else if (div_ovf_c) begin
      imm_y_c = (i_op == OP_DIV) ? i_A : '0;
    end
`ifdef ALU_MD_FAST_MUL_EN
    if (mul_op_c) imm_y_c = (i_op == OP_MUL) ? fp_c[XLEN-1:0] : fp_c[PW-1:XLEN];
`endif
  end

  // Sign fixup of the engine's final step.
  always_comb begin
    full_c = {core_hi_c, core_lo_c};
    prod_c = (a_neg_q ^ b_neg_q) ? (PW'(0) - full_c) : full_c;
    quo_c  = (a_neg_q ^ b_neg_q) ? (XLEN'(0) - core_lo_c) : core_lo_c;
    rem_c  = a_neg_q ? (XLEN'(0) - core_hi_c) : core_hi_c;
    case (op_q)
      OP_MUL:                       iter_y_c = prod_c[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: iter_y_c = prod_c[PW-1:XLEN];
      OP_DIV, OP_DIVU:              iter_y_c = quo_c;
      default:                      iter_y_c = rem_c;
    endcase
  end

  md_iter_core #(.XLEN(XLEN)) u_core (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (accept_c & iter_op_c),
    .i_is_div (div_op_c),
    .i_step   (state_q == ST_BUSY),
    .i_a      (a_mag_c),
    .i_b      (b_mag_c),
    .o_done_c (core_done_c),
    .o_hi_c   (core_hi_c),
    .o_lo_c   (core_lo_c)
  );

  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    y_d     = y_q;
    op_d    = op_q;
    a_neg_d = a_neg_q;
    b_neg_d = b_neg_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          op_d    = i_op;
          a_neg_d = a_neg_c;
          b_neg_d = b_neg_c;
          if (iter_op_c) begin
            state_d = ST_BUSY;
          end else begin
            valid_d = 1'b1;
            y_d     = imm_y_c;
          end
        end
      end
      ST_BUSY: begin
        if (core_done_c) begin
          state_d = ST_DONE;
          valid_d = 1'b1;
          y_d     = iter_y_c;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A flush drops whatever is in flight and leaves the last result in place.
    if (i_kill) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      y_d     = y_q;
    end
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      y_q     <= '0;
      op_q    <= OP_ADD;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      y_q     <= y_d;
      op_q    <= op_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_Y     = y_q;

endmodule

// File: tb/tb_alu_md_unit.sv
// Directed vector bench for alu_md_unit: latency, results, kill and reset abort.
module tb_alu_md_unit;
  import alu_pkg::*;

`ifdef ALU_MD_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [4:0]  i_op;
  logic [31:0] i_A;
  logic [31:0] i_B;
  logic        i_kill;
  logic        o_valid;
  logic [31:0] o_Y;

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] last_y;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  alu_md_unit #(.XLEN(32)) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_op    (i_op),
    .i_A     (i_A),
    .i_B     (i_B),
    .i_kill  (i_kill),
    .o_valid (o_valid),
    .o_Y     (o_Y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Issue one op, scramble inputs after accept, and measure latency and result.
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string name);
    int k;
    bit seen;
    bit rdy_low;
    @(negedge clk);
    i_valid = 1'b1; i_op = op; i_A = a; i_B = b;
    @(posedge clk); #1;
    i_valid = 1'b0; i_op = OP_XOR; i_A = ~a; i_B = ~b;
    k = 1; seen = 0; rdy_low = 1;
    while (!seen && k <= 80) begin
      if (o_valid) seen = 1;
      else begin
        if (o_ready) rdy_low = 0;
        @(posedge clk); #1;
        k++;
      end
    end
    check({name, " latency"}, 32'(k), 32'(lat));
    check({name, " result"}, seen ? o_Y : ~exp, exp);
    if (lat > 1) check({name, " ready low while busy"}, 32'(rdy_low), 32'd1);
    check({name, " ready at valid"}, 32'(o_ready), (lat == 1) ? 32'd1 : 32'd0);
    @(posedge clk); #1;
    check({name, " valid pulse ends"}, 32'(o_valid), 32'd0);
    check({name, " ready after valid"}, 32'(o_ready), 32'd1);
    last_y = exp;
  endtask

  // Start DIVU, abort at T+5 with kill or reset, then confirm the unit is usable.
  task automatic abort_seq(input bit use_rst, input string name);
    bit early_valid;
    int late_valid;
    early_valid = 0;
    late_valid  = 0;
    @(negedge clk);
    i_valid = 1'b1; i_op = OP_DIVU; i_A = 32'd1000; i_B = 32'd7;
    @(posedge clk); #1;
    i_valid = 1'b0;
    for (int c = 1; c < 5; c++) begin
      if (o_valid) early_valid = 1;
      @(posedge clk); #1;
    end
    if (o_valid) early_valid = 1;
    if (use_rst) i_rst = 1'b1; else i_kill = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0; i_kill = 1'b0;
    check({name, " ready at T+6"}, 32'(o_ready), 32'd1);
    if (use_rst) last_y = 32'h0;
    check({name, " o_Y after abort"}, o_Y, last_y);
    for (int c = 0; c < 40; c++) begin
      if (o_valid) late_valid++;
      @(posedge clk); #1;
    end
    check({name, " no valid before abort"}, 32'(early_valid), 32'd0);
    check({name, " no valid after abort"}, 32'(late_valid), 32'd0);
    do_op(OP_ADD, 32'd20, 32'd22, 32'd42, 1, {name, " follow-up ADD"});
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_op = OP_ADD; i_A = '0; i_B = '0; i_kill = 1'b0;
    last_y = 32'h0;

    vecs.push_back('{OP_ADD,    32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1});
    vecs.push_back('{OP_SUB,    32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1});
    vecs.push_back('{OP_AND,    32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1});
    vecs.push_back('{OP_OR,     32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1});
    vecs.push_back('{OP_XOR,    32'hAAAAAAAA, 32'hFFFF0000, 32'h5555AAAA, 1});
    vecs.push_back('{OP_SLL,    32'h00000001, 32'h00000023, 32'h00000008, 1});
    vecs.push_back('{OP_SRL,    32'h80000000, 32'h00000004, 32'h08000000, 1});
    vecs.push_back('{OP_SRA,    32'h80000000, 32'h00000024, 32'hF8000000, 1});
    vecs.push_back('{OP_SLT,    32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1});
    vecs.push_back('{OP_SLTU,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1});
    vecs.push_back('{5'd10,     32'h00000003, 32'h00000004, 32'h00000007, 1});
    vecs.push_back('{OP_DIVU,   32'h00001234, 32'h00000000, 32'hFFFFFFFF, 1});
    vecs.push_back('{OP_DIV,    32'h00001234, 32'h00000000, 32'hFFFFFFFF, 1});
    vecs.push_back('{OP_REMU,   32'h00001234, 32'h00000000, 32'h00001234, 1});
    vecs.push_back('{OP_REM,    32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1});
    vecs.push_back('{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
    vecs.push_back('{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});
    vecs.push_back('{OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, DIV_LAT});
    vecs.push_back('{OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, DIV_LAT});
    vecs.push_back('{OP_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT});
    vecs.push_back('{OP_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, DIV_LAT});
    vecs.push_back('{OP_DIVU,   32'h00000064, 32'h00000007, 32'h0000000E, DIV_LAT});
    vecs.push_back('{OP_REMU,   32'h00000064, 32'h00000007, 32'h00000002, DIV_LAT});
    vecs.push_back('{OP_DIVU,   32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, DIV_LAT});
    vecs.push_back('{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT});
    vecs.push_back('{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT});
    vecs.push_back('{OP_MULHSU, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, MUL_LAT});
    vecs.push_back('{OP_MUL,    32'h12345678, 32'h00000010, 32'h23456780, MUL_LAT});
    vecs.push_back('{OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, MUL_LAT});
    vecs.push_back('{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT});
    vecs.push_back('{OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT});
    vecs.push_back('{OP_MULH,   32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, MUL_LAT});

    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;
    @(posedge clk); #1;
    check("reset o_valid", 32'(o_valid), 32'd0);
    check("reset o_Y", o_Y, 32'h0);
    check("reset o_ready", 32'(o_ready), 32'd1);

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].lat,
            $sformatf("vec%0d op%0d", i, vecs[i].op));
    end

    abort_seq(1'b0, "kill DIVU");
    abort_seq(1'b1, "reset DIVU");

    // Kill and accept in the same cycle: the op is dropped.
    @(negedge clk);
    i_valid = 1'b1; i_kill = 1'b1; i_op = OP_ADD; i_A = 32'd1; i_B = 32'd2;
    @(posedge clk); #1;
    i_valid = 1'b0; i_kill = 1'b0;
    check("kill+accept no valid", 32'(o_valid), 32'd0);
    check("kill+accept o_Y held", o_Y, last_y);
    check("kill+accept ready", 32'(o_ready), 32'd1);
    @(posedge clk); #1;
    check("kill+accept no late valid", 32'(o_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
